// File: rtl/core_mem_pkg.sv
// Shared definitions for the core memory sequencer: state encoding, port count
// and a small helper that turns a port index into a one-hot port mask.
package core_mem_pkg;

   localparam int unsigned NPORT = 4;
   localparam int unsigned PW    = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_RS   = 3'd2,
      ST_WAIT = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } mem_state_t;

   function automatic logic [NPORT-1:0] port_mask(input logic [PW-1:0] idx);
      port_mask = NPORT'(1) << idx;
   endfunction

endpackage

// File: rtl/core_mem_arb.sv
// Four-way grant picker: fixed priority (port 0 highest) or round-robin starting
// after the last granted port. Grant is combinational; the last-grant pointer is registered.
module core_mem_arb
   import core_mem_pkg::*;
#(
   parameter int unsigned RR = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NPORT-1:0] i_req,
   input  logic             i_take,
   output logic             o_gnt_vld_c,
   output logic [PW-1:0]    o_gnt_idx_c
);

   logic [PW-1:0] r_last;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_cand;
   logic          w_found;

   // Pointer resets to the top port so the first round-robin winner is port 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last <= PW'(NPORT - 1);
      end else if (i_take) begin
         r_last <= w_idx;
      end
   end

   always_comb begin
      w_idx   = '0;
      w_cand  = '0;
      w_found = 1'b0;
      if (RR != 0) begin
         for (int k = 1; k <= int'(NPORT); k++) begin
            w_cand = r_last + PW'(k);
            if (!w_found && i_req[w_cand]) begin
               w_idx   = w_cand;
               w_found = 1'b1;
            end
         end
      end else begin
         for (int k = int'(NPORT) - 1; k >= 0; k--) begin
            if (i_req[k]) begin
               w_idx = PW'(k);
            end
         end
      end
   end

   assign o_gnt_vld_c = |i_req;
   assign o_gnt_idx_c = w_idx;

endmodule

// File: rtl/core_mem_sequencer.sv
// Sequences one core memory module shared by four membus ports: arbitrates cycle
// requests and runs the destructive-read / restore or read-pause-write core cycle.
module core_mem_sequencer
   import core_mem_pkg::*;
#(
   parameter int unsigned AW      = 18,
   parameter int unsigned DW      = 36,
   parameter int unsigned RD_CLKS = 4,
   parameter int unsigned WR_CLKS = 4,
   parameter int unsigned RR      = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NPORT-1:0]    memsel,
   input  logic [NPORT-1:0]    rq_cyc,
   input  logic [NPORT-1:0]    rd_rq,
   input  logic [NPORT-1:0]    wr_rq,
   input  logic [NPORT*AW-1:0] ma,
   input  logic [NPORT-1:0]    wr_rs,
   input  logic [NPORT*DW-1:0] mb_in,
   output logic [NPORT-1:0]    addr_ack,
   output logic [NPORT-1:0]    rd_rs,
   output logic [DW-1:0]       mb_out,
   output logic                busy,
   output logic [AW-1:0]       core_addr,
   output logic                core_rd,
   output logic                core_wr,
   output logic [DW-1:0]       core_wdata,
   input  logic [DW-1:0]       core_rdata
);

   localparam int unsigned CMAX = (RD_CLKS > WR_CLKS) ? RD_CLKS : WR_CLKS;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   mem_state_t       r_state;
   logic [CW-1:0]    r_cnt;
   logic [PW-1:0]    r_gnt;
   logic [AW-1:0]    r_addr;
   logic             r_rd;
   logic             r_wr;
   logic [DW-1:0]    r_mb;
   logic [DW-1:0]    r_mb_out;
   logic [NPORT-1:0] r_addr_ack;
   logic [NPORT-1:0] r_rd_rs;
   logic             r_busy;
   logic             r_core_rd;
   logic             r_core_wr;

   logic [NPORT-1:0] w_elig;
   logic             w_gnt_vld;
   logic [PW-1:0]    w_gnt_idx;
   logic             w_take;
   logic [AW-1:0]    w_ma    [NPORT];
   logic [DW-1:0]    w_mb_in [NPORT];

   for (genvar n = 0; n < int'(NPORT); n++) begin : g_unpack
      assign w_ma[n]    = ma[n*AW +: AW];
      assign w_mb_in[n] = mb_in[n*DW +: DW];
   end

   assign w_elig = memsel & rq_cyc & (rd_rq | wr_rq);
   assign w_take = (r_state == ST_IDLE) && w_gnt_vld;

   core_mem_arb #(
      .RR (RR)
   ) u_arb (
      .clk         (clk),
      .reset       (reset),
      .i_req       (w_elig),
      .i_take      (w_take),
      .o_gnt_vld_c (w_gnt_vld),
      .o_gnt_idx_c (w_gnt_idx)
   );

   // Core cycle FSM; only the granted port's strobes are looked at once a cycle starts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_gnt      <= '0;
         r_addr     <= '0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_mb       <= '0;
         r_mb_out   <= '0;
         r_addr_ack <= '0;
         r_rd_rs    <= '0;
         r_busy     <= 1'b0;
         r_core_rd  <= 1'b0;
         r_core_wr  <= 1'b0;
      end else begin
         r_addr_ack <= '0;
         r_rd_rs    <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_gnt     <= w_gnt_idx;
                  r_addr    <= w_ma[w_gnt_idx];
                  r_rd      <= rd_rq[w_gnt_idx];
                  r_wr      <= wr_rq[w_gnt_idx];
                  r_busy    <= 1'b1;
                  r_core_rd <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= ST_RD;
               end
            end
            ST_RD: begin
               if (r_cnt == CW'(RD_CLKS - 1)) begin
                  r_mb       <= core_rdata;
                  r_core_rd  <= 1'b0;
                  r_addr_ack <= port_mask(r_gnt);
                  r_state    <= ST_RS;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_RS: begin
               if (r_rd) begin
                  r_rd_rs  <= port_mask(r_gnt);
                  r_mb_out <= r_mb;
               end
               if (r_wr) begin
                  r_state <= ST_WAIT;
               end else begin
                  r_core_wr <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= ST_WR;
               end
            end
            ST_WAIT: begin
               // A requester that gives up without data gets its old word restored.
               if (wr_rs[r_gnt]) begin
                  r_mb      <= w_mb_in[r_gnt];
                  r_core_wr <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= ST_WR;
               end else if (!rq_cyc[r_gnt]) begin
                  r_core_wr <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= ST_WR;
               end
            end
            ST_WR: begin
               if (r_cnt == CW'(WR_CLKS - 1)) begin
                  r_core_wr <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign addr_ack   = r_addr_ack;
   assign rd_rs      = r_rd_rs;
   assign mb_out     = r_mb_out;
   assign busy       = r_busy;
   assign core_addr  = r_addr;
   assign core_rd    = r_core_rd;
   assign core_wr    = r_core_wr;
   assign core_wdata = r_mb;

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Directed bench for core_mem_sequencer: fixed-priority instance with a destructive
// core model, plus a round-robin instance used to observe grant order.
module tb_core_mem_sequencer;

   localparam int unsigned AW = 18;
   localparam int unsigned DW = 36;

   logic            clk;
   logic            reset;
   logic [3:0]      memsel;
   logic [3:0]      rq_cyc;
   logic [3:0]      rd_rq;
   logic [3:0]      wr_rq;
   logic [4*AW-1:0] ma;
   logic [3:0]      wr_rs;
   logic [4*DW-1:0] mb_in;

   logic [3:0]      addr_ack, rd_rs;
   logic [DW-1:0]   mb_out, core_wdata, core_rdata;
   logic            busy, core_rd, core_wr;
   logic [AW-1:0]   core_addr;

   logic [3:0]      rr_addr_ack, rr_rd_rs;
   logic [DW-1:0]   rr_mb_out, rr_core_wdata;
   logic            rr_busy, rr_core_rd, rr_core_wr;
   logic [AW-1:0]   rr_core_addr;

   int n_cmp = 0;
   int n_bad = 0;

   core_mem_sequencer #(.AW(AW), .DW(DW), .RD_CLKS(4), .WR_CLKS(4), .RR(0)) dut (
      .clk(clk), .reset(reset), .memsel(memsel), .rq_cyc(rq_cyc), .rd_rq(rd_rq),
      .wr_rq(wr_rq), .ma(ma), .wr_rs(wr_rs), .mb_in(mb_in), .addr_ack(addr_ack),
      .rd_rs(rd_rs), .mb_out(mb_out), .busy(busy), .core_addr(core_addr),
      .core_rd(core_rd), .core_wr(core_wr), .core_wdata(core_wdata),
      .core_rdata(core_rdata)
   );

   core_mem_sequencer #(.AW(AW), .DW(DW), .RD_CLKS(4), .WR_CLKS(4), .RR(1)) dut_rr (
      .clk(clk), .reset(reset), .memsel(memsel), .rq_cyc(rq_cyc), .rd_rq(rd_rq),
      .wr_rq(wr_rq), .ma(ma), .wr_rs(wr_rs), .mb_in(mb_in), .addr_ack(rr_addr_ack),
      .rd_rs(rr_rd_rs), .mb_out(rr_mb_out), .busy(rr_busy), .core_addr(rr_core_addr),
      .core_rd(rr_core_rd), .core_wr(rr_core_wr), .core_wdata(rr_core_wdata),
      .core_rdata('0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core array model: a read destroys the word once core_rd falls; writes restore it.
   bit [DW-1:0] mem [0:8191];
   logic        prev_rd = 1'b0;
   logic        pk_en   = 1'b0;
   logic [12:0] pk_a    = '0;
   logic [DW-1:0] pk_d  = '0;
   int          overlap = 0;
   int          rs_cnt  = 0;

   assign core_rdata = mem[core_addr[12:0]];

   always @(posedge clk) begin
      prev_rd <= core_rd;
      if (pk_en)                   mem[pk_a]            <= pk_d;
      else if (core_wr)            mem[core_addr[12:0]] <= core_wdata;
      else if (prev_rd && !core_rd) mem[core_addr[12:0]] <= '0;
   end

   always @(negedge clk) begin
      if (core_rd && core_wr) overlap <= overlap + 1;
      if (rd_rs != 4'b0000)   rs_cnt  <= rs_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %o expected %o", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [12:0] a, input logic [DW-1:0] d);
      pk_en = 1'b1; pk_a = a; pk_d = d;
      @(negedge clk);
      pk_en = 1'b0;
   endtask

   task automatic port_req(input int p, input logic [AW-1:0] a, input logic rd, input logic wr);
      memsel[p] = 1'b1; rq_cyc[p] = 1'b1; rd_rq[p] = rd; wr_rq[p] = wr;
      ma[p*AW +: AW] = a;
   endtask

   task automatic port_drop(input int p);
      memsel[p] = 1'b0; rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0; wr_rq[p] = 1'b0;
   endtask

   task automatic run_to_ack(output int cyc, output int rd_hi, output logic [3:0] ack);
      cyc = 0; rd_hi = 0; ack = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cyc++;
         if (core_rd) rd_hi++;
         if (addr_ack != 4'b0000) begin
            ack = addr_ack;
            break;
         end
      end
   endtask

   task automatic wait_idle(output int wr_hi, output logic ok);
      wr_hi = core_wr ? 1 : 0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (core_wr) wr_hi++;
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int            cyc, rd_hi, wr_hi, rs0, n0, n1;
      logic [3:0]    ack;
      logic          ok;
      logic [3:0]    g0 [4];
      logic [3:0]    g1 [4];
      logic [3:0]    exp_rr [4];

      reset = 1'b1; memsel = '0; rq_cyc = '0; rd_rq = '0; wr_rq = '0;
      ma = '0; wr_rs = '0; mb_in = '0;
      exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100; exp_rr[3] = 4'b1000;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_strobes", 64'({core_rd, core_wr, addr_ack, rd_rs}), 64'd0);
      chk("rst_regs", 64'({mb_out, core_addr, core_wdata}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // 1: plain read on p0, word restored
      poke(13'o20, 36'o200064000104);
      port_req(0, 18'o20, 1'b1, 1'b0);
      run_to_ack(cyc, rd_hi, ack);
      chk("t1_ack", 64'(ack), 64'b0001);
      chk("t1_ack_lat", 64'(cyc), 64'd5);
      chk("t1_rd_clks", 64'(rd_hi), 64'd4);
      chk("t1_addr", 64'(core_addr), 64'o20);
      @(negedge clk);
      chk("t1_rd_rs", 64'(rd_rs), 64'b0001);
      chk("t1_mb_out", 64'(mb_out), 64'o200064000104);
      port_drop(0);
      wait_idle(wr_hi, ok);
      chk("t1_idle", 64'(ok), 64'd1);
      chk("t1_wr_clks", 64'(wr_hi), 64'd4);
      chk("t1_restore", 64'(mem[13'o20]), 64'o200064000104);

      // 2: write on p1, stray wr_rs from p0 ignored
      poke(13'o30, 36'o123);
      rs0 = rs_cnt;
      port_req(1, 18'o30, 1'b0, 1'b1);
      run_to_ack(cyc, rd_hi, ack);
      chk("t2_ack", 64'(ack), 64'b0010);
      @(negedge clk);
      wr_rs = 4'b0001; mb_in[0 +: DW] = 36'o777777777777;
      @(negedge clk);
      chk("t2_held", 64'(core_wr), 64'd0);
      wr_rs = 4'b0010; mb_in[DW +: DW] = 36'o111777222666;
      @(negedge clk);
      wr_rs = '0;
      port_drop(1);
      chk("t2_wdata", 64'(core_wdata), 64'o111777222666);
      wait_idle(wr_hi, ok);
      chk("t2_idle", 64'(ok), 64'd1);
      chk("t2_mem", 64'(mem[13'o30]), 64'o111777222666);
      chk("t2_no_rd_rs", 64'(rs_cnt - rs0), 64'd0);

      // 4: read-modify-write on p2
      poke(13'o10410, 36'o333);
      port_req(2, 18'o10410, 1'b1, 1'b1);
      run_to_ack(cyc, rd_hi, ack);
      chk("t4_ack", 64'(ack), 64'b0100);
      @(negedge clk);
      chk("t4_rd_rs", 64'(rd_rs), 64'b0100);
      chk("t4_mb_out", 64'(mb_out), 64'o333);
      wr_rs = 4'b0100; mb_in[2*DW +: DW] = 36'o334;
      @(negedge clk);
      wr_rs = '0;
      port_drop(2);
      wait_idle(wr_hi, ok);
      chk("t4_idle", 64'(ok), 64'd1);
      chk("t4_mem", 64'(mem[13'o10410]), 64'o334);

      // 5: write on p3 abandoned in WAIT
      poke(13'o40, 36'o555);
      port_req(3, 18'o40, 1'b0, 1'b1);
      run_to_ack(cyc, rd_hi, ack);
      chk("t5_ack", 64'(ack), 64'b1000);
      @(negedge clk);
      port_drop(3);
      wait_idle(wr_hi, ok);
      chk("t5_idle", 64'(ok), 64'd1);
      chk("t5_wr_clks", 64'(wr_hi), 64'd4);
      chk("t5_restore", 64'(mem[13'o40]), 64'o555);

      // 6: reset during RD, then the held request is served
      port_req(0, 18'o50, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("t6_in_rd", 64'(core_rd), 64'd1);
      reset = 1'b1;
      #1;
      chk("t6_rst_out", 64'({core_rd, core_wr, busy, addr_ack}), 64'd0);
      chk("t6_rst_addr", 64'(core_addr), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      run_to_ack(cyc, rd_hi, ack);
      chk("t6_ack", 64'(ack), 64'b0001);
      chk("t6_ack_lat", 64'(cyc), 64'd5);
      @(negedge clk);
      port_drop(0);
      wait_idle(wr_hi, ok);
      chk("t6_idle", 64'(ok), 64'd1);

      // 3: all ports request; fixed priority vs round-robin grant order
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int p = 0; p < 4; p++) port_req(p, AW'(p + 'o60), 1'b1, 1'b0);
      n0 = 0; n1 = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (addr_ack != 4'b0000 && n0 < 4) begin g0[n0] = addr_ack; n0++; end
         if (rr_addr_ack != 4'b0000 && n1 < 4) begin g1[n1] = rr_addr_ack; n1++; end
         if (n0 == 4 && n1 == 4) break;
      end
      for (int p = 0; p < 4; p++) port_drop(p);
      chk("t3_cnt_fixed", 64'(n0), 64'd4);
      chk("t3_cnt_rr", 64'(n1), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < n0) chk($sformatf("t3_fixed_%0d", k), 64'(g0[k]), 64'b0001);
         if (k < n1) chk($sformatf("t3_rr_%0d", k), 64'(g1[k]), 64'(exp_rr[k]));
      end
      @(negedge clk);
      wait_idle(wr_hi, ok);
      chk("t3_idle", 64'(ok), 64'd1);
      repeat (2) @(negedge clk);
      chk("t3_rr_idle", 64'(rr_busy), 64'd0);
      chk("no_rd_wr_overlap", 64'(overlap), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
